// File: rtl/btn_debounce_ctrl_if.sv
// Button conditioning bus: raw pad input toward the debouncer and the
// conditioned level/strobe outputs back to the LED gating logic.
interface btn_debounce_ctrl_if;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic toggle_q;
  logic long_pulse;

  // Producer of the raw button / consumer of the conditioned outputs
  modport master (
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  toggle_q,
    input  long_pulse
  );

  // The debouncer itself
  modport slave (
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output toggle_q,
    output long_pulse
  );
endinterface

// File: rtl/btn_debounce_ctrl.sv
// Push-button conditioner for the LED blink logic.
// Synchronises the raw pad, debounces it with a counter-qualified FSM and
// produces a clean level, press/release strobes and a press-toggled latch.
// Optional long-press strobe is built only when BTN_LONG_PRESS_EN is defined;
// otherwise long_pulse is tied low.
module btn_debounce_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1500000,
  parameter int unsigned LONG_CYCLES     = 750000000,
  parameter int unsigned CNT_W           = 30
) (
  input  logic                 clk,
  input  logic                 reset_n,
  btn_debounce_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  // Reject parameter sets the debouncer cannot honour
  if ((DEBOUNCE_CYCLES < 32'd2) || (LONG_CYCLES <= DEBOUNCE_CYCLES) ||
      (CNT_W < $clog2(LONG_CYCLES))) begin : g_bad_cfg
    $error("btn_debounce_ctrl: illegal DEBOUNCE_CYCLES/LONG_CYCLES/CNT_W");
  end

  logic             sync_meta_r;
  logic             sync_r;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;

  logic             level_nxt_s;
  logic             press_nxt_s;
  logic             release_nxt_s;
  logic             toggle_nxt_s;
  logic             long_nxt_s;

  logic             level_r;
  logic             press_r;
  logic             release_r;
  logic             toggle_r;
  logic             long_r;

  // Two-flop synchroniser: the only logic that touches the raw pad
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= bus.btn_raw;
      sync_r      <= sync_meta_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: a change is accepted only after DEBOUNCE_CYCLES stable samples
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sync_r) state_nxt_s = ST_PRESS_WAIT;
        else        state_nxt_s = ST_IDLE;
      end
      ST_PRESS_WAIT: begin
        if (!sync_r)                state_nxt_s = ST_IDLE;
        else if (cnt_r == DEB_LAST) state_nxt_s = ST_PRESSED;
        else                        state_nxt_s = ST_PRESS_WAIT;
      end
      ST_PRESSED: begin
        if (!sync_r) state_nxt_s = ST_RELEASE_WAIT;
        else         state_nxt_s = ST_PRESSED;
      end
      ST_RELEASE_WAIT: begin
        if (sync_r)                 state_nxt_s = ST_PRESSED;
        else if (cnt_r == DEB_LAST) state_nxt_s = ST_IDLE;
        else                        state_nxt_s = ST_RELEASE_WAIT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Stability counter: clears on any state change, counts in the wait states and
  // holds at its last value rather than wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_nxt_s != state_r) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (((state_r == ST_PRESS_WAIT) || (state_r == ST_RELEASE_WAIT)) &&
                 (cnt_r != DEB_LAST)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_PRE  = CNT_W'(LONG_CYCLES - 32'd2);

  logic [CNT_W-1:0] hold_cnt_r;

  // Hold counter: restarts only on a fresh accepted press so release bounce
  // does not re-arm it, saturates after the strobe, clears back in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_r <= {CNT_W{1'b0}};
    end else if (state_nxt_s == ST_IDLE) begin
      hold_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_PRESS_WAIT) && (state_nxt_s == ST_PRESSED)) begin
      hold_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_PRESSED) && (hold_cnt_r != HOLD_LAST)) begin
      hold_cnt_r <= hold_cnt_r + CNT_W'(1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Long-press strobe fires on the step that takes the hold counter to its end
  always_comb begin
    long_nxt_s = 1'b0;
    if ((state_r == ST_PRESSED) && (hold_cnt_r == HOLD_PRE)) long_nxt_s = 1'b1;
    else                                                     long_nxt_s = 1'b0;
  end
`else
  // Long-press feature absent: strobe permanently low
  always_comb begin
    long_nxt_s = 1'b0;
  end
`endif

  // FSM outputs, computed from the upcoming state so the registered copies line
  // up with the state they describe
  always_comb begin
    level_nxt_s   = (state_nxt_s == ST_PRESSED) || (state_nxt_s == ST_RELEASE_WAIT);
    press_nxt_s   = (state_r == ST_PRESS_WAIT)   && (state_nxt_s == ST_PRESSED);
    release_nxt_s = (state_r == ST_RELEASE_WAIT) && (state_nxt_s == ST_IDLE);
    toggle_nxt_s  = toggle_r ^ press_nxt_s;
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      toggle_r  <= 1'b0;
      long_r    <= 1'b0;
    end else begin
      level_r   <= level_nxt_s;
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
      toggle_r  <= toggle_nxt_s;
      long_r    <= long_nxt_s;
    end
  end

  assign bus.btn_level     = level_r;
  assign bus.press_pulse   = press_r;
  assign bus.release_pulse = release_r;
  assign bus.toggle_q      = toggle_r;
  assign bus.long_pulse    = long_r;

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Self-checking bench for btn_debounce_ctrl (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// Expected strobes are queued with their cycle stamp when the button is driven
// and popped when the DUT emits them. Long-press expectations follow the
// BTN_LONG_PRESS_EN macro.
module tb_btn_debounce_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  // Input driven at a falling edge with cycle count d appears on the outputs
  // after rising edge d+1+DEB+2.
  localparam int LAT  = DEB + 3;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t  sb_q[$];
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;
  bit   exp_tog = 1'b0;
  int   d;
  int   r;

  btn_debounce_ctrl_if bus ();

  btn_debounce_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .CNT_W           (30)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to time-stamp expectations
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag, input int kind);
    ev_t e;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_unexpected"}, cyc, -1);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "_kind"}, kind, e.kind);
      check_eq({tag, "_cycle"}, cyc, e.cyc);
    end
  endtask

  // Advance n falling edges, scoring any strobe seen on the way
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.press_pulse) begin
          pop_check("press", K_PRESS);
          exp_tog = !exp_tog;
          check_eq("toggle", bus.toggle_q, exp_tog);
        end
        if (bus.long_pulse)    pop_check("long", K_LONG);
        if (bus.release_pulse) pop_check("release", K_RELEASE);
      end else begin
        exp_tog = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic v, output int at);
    tick(1);
    bus.btn_raw = v;
    at = cyc;
  endtask

  task automatic expect_press(input int at, input bit long_hold);
    push_ev(K_PRESS, at + LAT);
    if (LONG_EN && long_hold) push_ev(K_LONG, at + LAT + LONG - 1);
  endtask

  initial begin
    bus.btn_raw = 1'b1;
    reset_n     = 1'b0;
    tick(3);

    // 1: reset with button held, then release reset
    check_eq("rst_level",   bus.btn_level,     0);
    check_eq("rst_press",   bus.press_pulse,   0);
    check_eq("rst_release", bus.release_pulse, 0);
    check_eq("rst_toggle",  bus.toggle_q,      0);
    check_eq("rst_long",    bus.long_pulse,    0);
    reset_n = 1'b1;
    d = cyc;
    expect_press(d, 1'b0);
    tick(LAT - 1);
    check_eq("t1_level_pre", bus.btn_level, 0);
    tick(1);
    check_eq("t1_level", bus.btn_level, 1);
    drive(1'b0, r);
    push_ev(K_RELEASE, r + LAT);
    tick(LAT - 1);
    check_eq("t1_rel_level_pre", bus.btn_level, 1);
    tick(1);
    check_eq("t1_rel_level", bus.btn_level, 0);
    tick(3);

    // 2: clean press held 30 cycles
    drive(1'b1, d);
    expect_press(d, 1'b1);
    tick(LAT - 1);
    check_eq("t2_level_pre", bus.btn_level, 0);
    tick(1);
    check_eq("t2_level", bus.btn_level, 1);
    tick(29 - LAT);
    drive(1'b0, r);
    push_ev(K_RELEASE, r + LAT);
    tick(LAT + 3);
    check_eq("t2_rel_level", bus.btn_level, 0);

    // 3: bounce 1,0,1,0 two cycles each, then stable high
    drive(1'b1, d);
    tick(1);
    drive(1'b0, d);
    tick(1);
    drive(1'b1, d);
    tick(1);
    drive(1'b0, d);
    tick(1);
    check_eq("t3_bounce_level", bus.btn_level, 0);
    drive(1'b1, d);
    expect_press(d, 1'b0);
    tick(LAT + 2);
    check_eq("t3_level", bus.btn_level, 1);
    drive(1'b0, r);
    push_ev(K_RELEASE, r + LAT);
    tick(LAT + 3);

    // 4: three-cycle low glitch while pressed
    drive(1'b1, d);
    expect_press(d, 1'b0);
    tick(LAT + 2);
    drive(1'b0, r);
    tick(2);
    drive(1'b1, r);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check_eq("t4_level", bus.btn_level, 1);
    end
    drive(1'b0, r);
    push_ev(K_RELEASE, r + LAT);
    tick(LAT + 3);

    // 5: long hold of 60 cycles
    drive(1'b1, d);
    expect_press(d, 1'b1);
    tick(59);
    drive(1'b0, r);
    push_ev(K_RELEASE, r + LAT);
    tick(LAT + 3);
    check_eq("t5_level", bus.btn_level, 0);

    // 6a: reset during press qualification
    drive(1'b1, d);
    tick(3);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6a_level",  bus.btn_level, 0);
    check_eq("t6a_toggle", bus.toggle_q,  0);
    bus.btn_raw = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(15);
    check_eq("t6a_after", bus.btn_level, 0);

    // 6b: reset while pressed
    drive(1'b1, d);
    expect_press(d, 1'b0);
    tick(LAT + 3);
    check_eq("t6b_level_pre", bus.btn_level, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6b_level",  bus.btn_level,   0);
    check_eq("t6b_toggle", bus.toggle_q,    0);
    check_eq("t6b_press",  bus.press_pulse, 0);
    bus.btn_raw = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(15);
    check_eq("t6b_after_level",  bus.btn_level, 0);
    check_eq("t6b_after_toggle", bus.toggle_q,  0);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
